// File: rtl/plru_way_controller.sv
// Tree pseudo-LRU way controller: one 7-bit PLRU tree per set, hit/victim way
// select per request, and a sequential flush that clears every tree.
module plru_way_controller #(
  parameter int unsigned WAYS       = 8,
  parameter int unsigned SETS       = 16,
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INDEX_BITS-1:0] req_index,
  input  logic                  req_hit,
  input  logic [2:0]            req_hit_way,
  input  logic                  flush_req,
  output logic                  resp_valid,
  output logic [2:0]            resp_way,
  output logic                  resp_victim,
  output logic                  flush_done
);

  localparam int unsigned TREE_W = WAYS - 1;
  localparam int unsigned CNT_W  = INDEX_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_SET = CNT_W'(SETS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    RESPOND = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  accept;

  logic [TREE_W-1:0]     tree [SETS];
  logic [INDEX_BITS-1:0] idx_q;
  logic                  hit_q;
  logic [2:0]            hit_way_q;

  logic [TREE_W-1:0]     cur;
  logic [TREE_W-1:0]     upd;
  logic [3:0]            lvl2;
  logic [3:0]            lvl2_upd;
  logic [2:0]            victim;
  logic [2:0]            way_sel;

  // State and flush counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; a flush takes priority over a simultaneous request
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end else if (req_valid) begin
          state_next = LOOKUP;
          accept     = 1'b1;
        end
      end
      LOOKUP:  state_next = RESPOND;
      RESPOND: state_next = IDLE;
      FLUSH: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_SET) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the accepted request for the lookup cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= '0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
    end else if (accept) begin
      idx_q     <= req_index;
      hit_q     <= req_hit;
      hit_way_q <= req_hit_way;
    end
  end

  // Victim walk and path update: each node on the accessed path points away
  always_comb begin
    cur       = tree[idx_q];
    lvl2      = cur[6:3];
    victim    = '0;
    victim[2] = cur[0];
    victim[1] = victim[2] ? cur[2] : cur[1];
    victim[0] = lvl2[victim[2:1]];
    way_sel   = hit_q ? hit_way_q : victim;
    upd       = cur;
    upd[0]    = ~way_sel[2];
    if (way_sel[2]) upd[2] = ~way_sel[1];
    else            upd[1] = ~way_sel[1];
    lvl2_upd  = lvl2;
    lvl2_upd[way_sel[2:1]] = ~way_sel[0];
    upd[6:3]  = lvl2_upd;
  end

  // Tree storage: write-back on lookup, one set cleared per flush cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SETS); i++) tree[i] <= '0;
    end else if (state == LOOKUP) begin
      tree[idx_q] <= upd;
    end else if (state == FLUSH) begin
      tree[cnt[INDEX_BITS-1:0]] <= '0;
    end
  end

  // Registered outputs derived from next state; way/victim hold until next lookup
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      flush_done  <= 1'b0;
      resp_way    <= '0;
      resp_victim <= 1'b0;
    end else begin
      req_ready   <= (state_next == IDLE);
      resp_valid  <= (state_next == RESPOND);
      flush_done  <= (state_next == FLUSH) && (cnt_next == LAST_SET);
      if (state == LOOKUP) begin
        resp_way    <= way_sel;
        resp_victim <= ~hit_q;
      end
    end
  end

endmodule

// File: tb/tb_plru_way_controller.sv
// Directed bench for plru_way_controller: victim order, hit updates, set
// isolation, flush timing/priority and asynchronous reset mid-operation.
module tb_plru_way_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_index;
  logic       req_hit;
  logic [2:0] req_hit_way;
  logic       flush_req;
  logic       resp_valid;
  logic [2:0] resp_way;
  logic       resp_victim;
  logic       flush_done;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] exp_seq [0:8];

  plru_way_controller #(.WAYS(8), .SETS(16), .INDEX_BITS(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_hit     (req_hit),
    .req_hit_way (req_hit_way),
    .flush_req   (flush_req),
    .resp_valid  (resp_valid),
    .resp_way    (resp_way),
    .resp_victim (resp_victim),
    .flush_done  (flush_done)
  );

  always #5 clock = ~clock;

  // Step to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Bounded wait for req_ready; an expired bound is a miscompare
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: req_ready timeout, got %b want 1", name, req_ready);
    end
  endtask

  // Issue one request; report resp_valid at T+1, outputs at T+2 and T+3
  task automatic drive_req(input logic [3:0] idx, input logic hit, input logic [2:0] hw,
                           output logic pre, output logic rv, output logic [2:0] rw,
                           output logic rvic, output logic rdy3, output logic [2:0] hold);
    wait_ready("drive_req");
    req_valid   = 1'b1;
    req_index   = idx;
    req_hit     = hit;
    req_hit_way = hw;
    tick();
    req_valid   = 1'b0;
    req_hit     = 1'b0;
    pre = resp_valid;
    tick();
    rv   = resp_valid;
    rw   = resp_way;
    rvic = resp_victim;
    tick();
    rdy3 = req_ready;
    hold = resp_way;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_vec++; if (req_ready !== 1'b1)   begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    n_vec++; if (resp_way !== 3'd0)    begin n_err++; $display("FAIL reset_way: got %0d want 0", resp_way); end
    n_vec++; if (resp_victim !== 1'b0) begin n_err++; $display("FAIL reset_victim: got %b want 0", resp_victim); end
    n_vec++; if (flush_done !== 1'b0)  begin n_err++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_miss_sequence();
    logic pre, rv, rvic, rdy3;
    logic [2:0] rw, hold;
    exp_seq = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7, 3'd0};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive_req(4'd3, 1'b0, 3'd0, pre, rv, rw, rvic, rdy3, hold);
      n_vec++;
      if ({pre, rv, rvic, rdy3} !== 4'b0111 || rw !== exp_seq[i] || hold !== exp_seq[i]) begin
        n_err++;
        $display("FAIL miss_seq[%0d]: got pre=%b valid=%b way=%0d victim=%b ready3=%b hold=%0d want pre=0 valid=1 way=%0d victim=1 ready3=1 hold=%0d",
                 i, pre, rv, rw, rvic, rdy3, hold, exp_seq[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_hit_update();
    logic pre, rv, rvic, rdy3;
    logic [2:0] rw, hold;
    logic       hits [0:3];
    logic [2:0] hways [0:3];
    logic [2:0] ways [0:3];
    hits  = '{1'b1, 1'b0, 1'b1, 1'b0};
    hways = '{3'd6, 3'd0, 3'd0, 3'd0};
    ways  = '{3'd6, 3'd0, 3'd0, 3'd4};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(4'd5, hits[i], hways[i], pre, rv, rw, rvic, rdy3, hold);
      n_vec++;
      if (rv !== 1'b1 || rw !== ways[i] || rvic !== ~hits[i]) begin
        n_err++;
        $display("FAIL hit_update[%0d]: got valid=%b way=%0d victim=%b want valid=1 way=%0d victim=%b",
                 i, rv, rw, rvic, ways[i], ~hits[i]);
      end
    end
  endtask

  task automatic test_set_isolation();
    logic pre, rv, rvic, rdy3;
    logic [2:0] rw, hold;
    logic [2:0] exp3 [0:2];
    exp3 = '{3'd0, 3'd4, 3'd2};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_req((i % 2 == 0) ? 4'd0 : 4'd15, 1'b0, 3'd0, pre, rv, rw, rvic, rdy3, hold);
      n_vec++;
      if (rv !== 1'b1 || rw !== exp3[i/2] || rvic !== 1'b1) begin
        n_err++;
        $display("FAIL set_isolation[%0d]: got valid=%b way=%0d victim=%b want valid=1 way=%0d victim=1",
                 i, rv, rw, rvic, exp3[i/2]);
      end
    end
  endtask

  task automatic test_flush();
    logic pre, rv, rvic, rdy3;
    logic [2:0] rw, hold;
    int done_at;
    int ready_high;
    apply_reset();
    for (int i = 0; i < 3; i++) drive_req(4'd7, 1'b0, 3'd0, pre, rv, rw, rvic, rdy3, hold);
    wait_ready("flush");
    flush_req = 1'b1;
    tick();
    flush_req  = 1'b0;
    done_at    = -1;
    ready_high = 0;
    for (int k = 1; k <= 16; k++) begin
      if (flush_done === 1'b1 && done_at < 0) done_at = k;
      if (req_ready !== 1'b0) ready_high++;
      if (k < 16) tick();
    end
    n_vec++; if (done_at !== 16) begin n_err++; $display("FAIL flush_done_cycle: got %0d want 16", done_at); end
    n_vec++; if (ready_high !== 0) begin n_err++; $display("FAIL flush_ready_low: got %0d ready cycles want 0", ready_high); end
    tick();
    n_vec++; if (req_ready !== 1'b1 || flush_done !== 1'b0) begin
      n_err++; $display("FAIL flush_exit: got ready=%b done=%b want ready=1 done=0", req_ready, flush_done);
    end
    drive_req(4'd7, 1'b0, 3'd0, pre, rv, rw, rvic, rdy3, hold);
    n_vec++; if (rv !== 1'b1 || rw !== 3'd0) begin
      n_err++; $display("FAIL flush_cleared: got valid=%b way=%0d want valid=1 way=0", rv, rw);
    end
  endtask

  task automatic test_flush_priority();
    int done_at;
    int resp_seen;
    apply_reset();
    wait_ready("flush_priority");
    flush_req   = 1'b1;
    req_valid   = 1'b1;
    req_index   = 4'd2;
    req_hit     = 1'b0;
    req_hit_way = 3'd0;
    tick();
    flush_req = 1'b0;
    done_at   = -1;
    resp_seen = 0;
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      if (resp_valid === 1'b1) resp_seen++;
      if (flush_done === 1'b1) done_at = k;
      else tick();
    end
    n_vec++; if (done_at !== 16) begin n_err++; $display("FAIL prio_done_cycle: got %0d want 16", done_at); end
    n_vec++; if (resp_seen !== 0) begin n_err++; $display("FAIL prio_no_resp: got %0d pulses want 0", resp_seen); end
    tick();
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL prio_ready_after: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL prio_accept: got ready=%b want 0", req_ready); end
    tick();
    n_vec++; if (resp_valid !== 1'b1 || resp_way !== 3'd0 || resp_victim !== 1'b1) begin
      n_err++; $display("FAIL prio_resp: got valid=%b way=%0d victim=%b want valid=1 way=0 victim=1",
                        resp_valid, resp_way, resp_victim);
    end
  endtask

  task automatic test_reset_lookup();
    logic pre, rv, rvic, rdy3;
    logic [2:0] rw, hold;
    int resp_seen;
    apply_reset();
    for (int i = 0; i < 2; i++) drive_req(4'd4, 1'b0, 3'd0, pre, rv, rw, rvic, rdy3, hold);
    wait_ready("reset_lookup");
    req_valid = 1'b1;
    req_index = 4'd4;
    req_hit   = 1'b0;
    tick();
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    n_vec++; if ({req_ready, resp_valid, resp_victim, flush_done} !== 4'b1000 || resp_way !== 3'd0) begin
      n_err++; $display("FAIL reset_in_lookup: got ready=%b valid=%b way=%0d victim=%b done=%b want 1 0 0 0 0",
                        req_ready, resp_valid, resp_way, resp_victim, flush_done);
    end
    tick();
    reset_n   = 1'b1;
    resp_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid !== 1'b0) resp_seen++;
      tick();
    end
    n_vec++; if (resp_seen !== 0) begin n_err++; $display("FAIL reset_lookup_dropped: got %0d pulses want 0", resp_seen); end
    drive_req(4'd4, 1'b0, 3'd0, pre, rv, rw, rvic, rdy3, hold);
    n_vec++; if (rv !== 1'b1 || rw !== 3'd0) begin
      n_err++; $display("FAIL reset_lookup_tree: got valid=%b way=%0d want valid=1 way=0", rv, rw);
    end
  endtask

  task automatic test_reset_flush();
    logic pre, rv, rvic, rdy3;
    logic [2:0] rw, hold;
    apply_reset();
    for (int i = 0; i < 2; i++) drive_req(4'd12, 1'b0, 3'd0, pre, rv, rw, rvic, rdy3, hold);
    wait_ready("reset_flush");
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    reset_n = 1'b0;
    #1;
    n_vec++; if ({req_ready, resp_valid, resp_victim, flush_done} !== 4'b1000 || resp_way !== 3'd0) begin
      n_err++; $display("FAIL reset_in_flush: got ready=%b valid=%b way=%0d victim=%b done=%b want 1 0 0 0 0",
                        req_ready, resp_valid, resp_way, resp_victim, flush_done);
    end
    tick();
    reset_n = 1'b1;
    drive_req(4'd12, 1'b0, 3'd0, pre, rv, rw, rvic, rdy3, hold);
    n_vec++; if (rv !== 1'b1 || rw !== 3'd0 || rvic !== 1'b1) begin
      n_err++; $display("FAIL reset_flush_tree: got valid=%b way=%0d victim=%b want valid=1 way=0 victim=1", rv, rw, rvic);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    req_index   = '0;
    req_hit     = 1'b0;
    req_hit_way = '0;
    flush_req   = 1'b0;
    test_reset();
    test_miss_sequence();
    test_hit_update();
    test_set_isolation();
    test_flush();
    test_flush_priority();
    test_reset_lookup();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/plru_way_controller.md
# plru_way_controller

Tree pseudo-LRU replacement controller for the 8-way L2 set datapath. For each request it produces the 3-bit way select that drives the 8:1 way multiplexor: the hit way on a hit, or the PLRU victim way on a miss. It keeps one 7-bit PLRU tree per set and updates it on every access. It also runs a multi-cycle flush that resets every tree. It sits between the tag-compare stage and the data/way multiplexors.

## Interface
Parameters:
- WAYS, 8, associativity; fixed at 8 (3-bit way select, 7 tree bits per set).
- SETS, 16, number of sets; must be a power of two.
- INDEX_BITS, 4, log2(SETS).

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a lookup request is present.
- req_ready  out  1  controller can accept a request or flush.
- req_index  in  INDEX_BITS  set index.
- req_hit  in  1  1 means hit, 0 means miss.
- req_hit_way  in  3  hit way; ignored when req_hit=0.
- flush_req  in  1  request to clear all PLRU trees.
- resp_valid  out  1  one-cycle pulse; resp_way and resp_victim are valid.
- resp_way  out  3  way select for the way multiplexor.
- resp_victim  out  1  1 means resp_way is a replacement victim (miss).
- flush_done  out  1  one-cycle pulse when the flush completes.

## Operation
- Storage: tree[SETS][7], with bit b0 as root, b1/b2 at level 1, and b3..b6 at level 2.
- Bit semantics: 0 means the victim lies in the lower half, 1 means the upper half.
- Victim walk:
  - v[2] = b0.
  - v[1] = b(1+v[2]).
  - v[0] = b(3+2·v[2]+v[1]).
- Update on access to way w (hit way, or the victim on a miss), so each node on the path points away from w:
  - b0 := ~w[2].
  - b(1+w[2]) := ~w[1].
  - b(3+w[2:1]) := ~w[0].
  - All other bits are unchanged.
- FSM states:
  - IDLE: req_ready=1.
    - flush_req=1 goes to FLUSH, with flush counter := 0. flush_req has priority over a simultaneous req_valid; that request is not accepted.
    - Otherwise req_valid=1 accepts the request: latch index, hit, and hit_way, then go to LOOKUP.
  - LOOKUP: req_ready=0.
    - Read tree[index] and select w.
    - Write the updated tree and register resp_way=w and resp_victim=~hit.
    - Go to RESPOND.
  - RESPOND: resp_valid=1 for this cycle only, then go to IDLE.
  - FLUSH: req_ready=0.
    - Each cycle write tree[counter] := 0 and increment the counter.
    - At counter=SETS-1, pulse flush_done, then go to IDLE.
- A flush_req arriving outside IDLE is ignored. The requester holds it until req_ready=1.
- The counter is INDEX_BITS+1 wide; no wrap-around reaches the array.

## Timing
- Reset, asserted at any time including mid-LOOKUP or mid-FLUSH:
  - All trees go to 0 immediately; state goes to IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_way=0, resp_victim=0, flush_done=0.
  - A request in flight is dropped with no response.
- Request acceptance happens on the edge where req_valid & req_ready is sampled high (cycle T).
  - resp_valid is high during cycle T+2.
  - req_ready returns to 1 in cycle T+3.
  - Throughput is one request per 3 cycles.
- The tree write commits at the end of cycle T+1. A back-to-back request to the same set therefore sees the updated tree.
- resp_way and resp_victim hold their values after resp_valid drops, until the next LOOKUP.
- Flush accepted at cycle T:
  - Sets 0..SETS-1 are cleared in cycles T+1..T+SETS.
  - flush_done is high in cycle T+SETS.
  - req_ready is 1 again from cycle T+SETS+1.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then miss on set 3: resp_way=0 and resp_victim=1 at T+2. Repeat the miss on set 3: resp_way=4. Then 2, 6, 1, 5, 3, 7; the 9th miss returns 0.
- After reset, hit on set 5 way 6 (resp_way=6, resp_victim=0), then miss on set 5: victim=0. Hit way 0, then miss on set 5: victim=4.
- Interleave misses on sets 0 and 15: each set progresses independently through 0, 4, 2, …; no cross-set corruption.
- Warm set 7 with 3 misses, then flush: flush_done exactly 16 cycles after acceptance with req_ready=0 throughout. The next miss on set 7 returns 0.
- Assert flush_req and req_valid in the same IDLE cycle: the flush wins, no resp_valid pulse, and the request is accepted after flush_done.
- Drop reset_n in LOOKUP and separately in FLUSH cycle 5: outputs go to their reset values immediately with no resp_valid. The next miss on any set returns 0.
